// File: rtl/hpu_pkg.sv
// Shared types and the selection rule for the multi-lane HPU pivot search.
// The same merge function is used by the lane tree and the running-best merge.
package hpu_pkg;

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned ROW_IDX_W = 8;

  typedef enum logic {
    PIV_MAX_ABS  = 1'b0,
    PIV_FIRST_NZ = 1'b1
  } pivot_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_DONE    = 2'd3
  } pivot_state_e;

  typedef struct packed {
    logic                 vld;
    logic [DATA_W-1:0]    absval;
    logic [ROW_IDX_W-1:0] row;
    logic [DATA_W-1:0]    value;
  } pivot_cand_t;

  // Magnitude as unsigned; the most negative value maps to 2^(DATA_W-1).
  function automatic logic [DATA_W-1:0] pivot_abs(input logic [DATA_W-1:0] v);
    return v[DATA_W-1] ? ((~v) + DATA_W'(1)) : v;
  endfunction

  // a is earlier in arrival order than b; returns the surviving candidate.
  function automatic pivot_cand_t pivot_merge(
    input pivot_cand_t       a,
    input pivot_cand_t       b,
    input pivot_mode_e       mode,
    input logic [DATA_W-1:0] eps,
    input logic              tie_lowest
  );
    logic take_b;
    take_b = 1'b0;
    if (b.vld) begin
      if (!a.vld) begin
        take_b = 1'b1;
      end else if (mode == PIV_MAX_ABS) begin
        take_b = (b.absval > a.absval) || (!tie_lowest && (b.absval == a.absval));
      end else begin
        take_b = !(a.absval > eps) && (b.absval > eps);
      end
    end
    return take_b ? b : a;
  endfunction

endpackage

// File: rtl/pivot_lane_reduce.sv
// Stage 1 of the pivot search: per-lane magnitude, lane masking and a
// registered LANES-to-1 reduction tree (lower lane = earlier in arrival order).
module pivot_lane_reduce
  import hpu_pkg::*;
#(
  parameter int unsigned LANES      = 4,
  parameter int unsigned TIE_LOWEST = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_fire,
  input  pivot_mode_e             mode,
  input  logic [DATA_W-1:0]       eps,
  input  logic [LANES*DATA_W-1:0] in_value,
  input  logic [ROW_IDX_W-1:0]    in_row_base,
  input  logic [LANES-1:0]        lane_en,
  output pivot_cand_t             red_cand,
  output logic                    red_fire
);

  localparam int unsigned NODES = 2 * LANES - 1;

  pivot_cand_t node [NODES];

  // Heap-ordered tree: node k has children 2k+1 (lower lanes) and 2k+2.
  always_comb begin
    for (int n = 0; n < int'(NODES); n++) begin
      node[n] = '0;
    end
    for (int i = 0; i < int'(LANES); i++) begin
      if (lane_en[i]) begin
        node[int'(LANES) - 1 + i].vld    = 1'b1;
        node[int'(LANES) - 1 + i].value  = in_value[i*DATA_W +: DATA_W];
        node[int'(LANES) - 1 + i].absval = pivot_abs(in_value[i*DATA_W +: DATA_W]);
        node[int'(LANES) - 1 + i].row    = in_row_base + ROW_IDX_W'(i);
      end
    end
    for (int k = int'(LANES) - 2; k >= 0; k--) begin
      node[k] = pivot_merge(node[2*k+1], node[2*k+2], mode, eps, TIE_LOWEST != 0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      red_cand <= '0;
      red_fire <= 1'b0;
    end else begin
      red_fire <= in_fire;
      if (in_fire) begin
        red_cand <= node[0];
      end
    end
  end

endmodule

// File: rtl/hpu_pivot_search_mc.sv
// Multi-lane pivot search for LU factorisation: max-|v| or first-above-threshold.
// Optional HPU_PIVOT_STATS_EN adds pivot_elem_cnt and pivot_tie outputs.
module hpu_pivot_search_mc #(
  parameter int unsigned DATA_W     = hpu_pkg::DATA_W,
  parameter int unsigned ROW_IDX_W  = hpu_pkg::ROW_IDX_W,
  parameter int unsigned LANES      = 4,
  parameter int unsigned MAX_ELEMS  = 256,
  parameter int unsigned TIE_LOWEST = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    pivot_start,
  output logic                    pivot_busy,
  input  logic                    mode,
  input  logic [DATA_W-1:0]       eps_thresh,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*DATA_W-1:0] in_value,
  input  logic [ROW_IDX_W-1:0]    in_row_base,
  input  logic [LANES-1:0]        in_lane_mask,
  input  logic                    in_last,
  output logic                    pivot_valid,
  input  logic                    pivot_ready,
  output logic [ROW_IDX_W-1:0]    pivot_row,
  output logic [DATA_W-1:0]       pivot_value,
  output logic                    pivot_fail,
  output logic                    pivot_ovf
`ifdef HPU_PIVOT_STATS_EN
  ,
  output logic [$clog2(MAX_ELEMS+2)-1:0] pivot_elem_cnt,
  output logic                           pivot_tie
`endif
);

  import hpu_pkg::*;

  // DATA_W / ROW_IDX_W must match the widths of pivot_cand_t in hpu_pkg.
  localparam int unsigned CNT_W = $clog2(MAX_ELEMS + 2);
  localparam int unsigned SUM_W = $clog2(MAX_ELEMS + LANES + 2);

  pivot_state_e      state, state_next;
  pivot_mode_e       mode_q;
  logic [DATA_W-1:0] eps_q;
  pivot_cand_t       best, red_cand;
  logic              red_fire;
  logic [CNT_W-1:0]  cnt_q, cnt_next;
  logic [LANES-1:0]  lane_en;
  logic              start_fire, accept, res_hs, ovf_seen;

  // Drop lanes once MAX_ELEMS enabled lanes have been seen; count saturates.
  always_comb begin
    logic [SUM_W-1:0] run;
    run     = SUM_W'(cnt_q);
    lane_en = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      if (in_lane_mask[i]) begin
        lane_en[i] = (run < SUM_W'(MAX_ELEMS));
        run        = run + SUM_W'(1);
      end
    end
    cnt_next = (run > SUM_W'(MAX_ELEMS + 1)) ? CNT_W'(MAX_ELEMS + 1) : CNT_W'(run);
  end

  assign ovf_seen = (cnt_q > CNT_W'(MAX_ELEMS));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    start_fire = 1'b0;
    accept     = 1'b0;
    res_hs     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pivot_start) begin
          start_fire = 1'b1;
          state_next = ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        if (in_valid) begin
          accept = 1'b1;
          if (in_last) begin
            state_next = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: state_next = ST_DONE;
      ST_DONE: begin
        if (pivot_valid && pivot_ready) begin
          res_hs     = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  pivot_lane_reduce #(
    .LANES      (LANES),
    .TIE_LOWEST (TIE_LOWEST)
  ) u_lane_reduce (
    .clk         (clk),
    .rst         (rst),
    .in_fire     (accept),
    .mode        (mode_q),
    .eps         (eps_q),
    .in_value    (in_value),
    .in_row_base (in_row_base),
    .lane_en     (lane_en),
    .red_cand    (red_cand),
    .red_fire    (red_fire)
  );

  // Control latches, stage-2 merge and the registered result channel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q      <= PIV_MAX_ABS;
      eps_q       <= '0;
      best        <= '0;
      cnt_q       <= '0;
      in_ready    <= 1'b0;
      pivot_busy  <= 1'b0;
      pivot_valid <= 1'b0;
      pivot_row   <= '0;
      pivot_value <= '0;
      pivot_fail  <= 1'b0;
      pivot_ovf   <= 1'b0;
    end else begin
      in_ready <= (state_next == ST_COLLECT);
      if (start_fire) begin
        mode_q     <= pivot_mode_e'(mode);
        eps_q      <= eps_thresh;
        best       <= '0;
        cnt_q      <= '0;
        pivot_busy <= 1'b1;
      end
      if (accept) begin
        cnt_q <= cnt_next;
      end
      if (red_fire) begin
        best <= pivot_merge(best, red_cand, mode_q, eps_q, TIE_LOWEST != 0);
      end
      if ((state == ST_DONE) && !pivot_valid) begin
        pivot_valid <= 1'b1;
        pivot_row   <= best.row;
        pivot_value <= best.value;
        pivot_fail  <= ovf_seen || !best.vld || (best.absval <= eps_q);
        pivot_ovf   <= ovf_seen;
      end
      if (res_hs) begin
        pivot_busy  <= 1'b0;
        pivot_valid <= 1'b0;
        pivot_row   <= '0;
        pivot_value <= '0;
        pivot_fail  <= 1'b0;
        pivot_ovf   <= 1'b0;
      end
    end
  end

`ifdef HPU_PIVOT_STATS_EN
  logic tie_q;

  // Tie means a later beat's winner had the same magnitude as the running best.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tie_q          <= 1'b0;
      pivot_elem_cnt <= '0;
      pivot_tie      <= 1'b0;
    end else begin
      if (start_fire) begin
        tie_q <= 1'b0;
      end else if (red_fire && red_cand.vld && best.vld && (red_cand.absval == best.absval)) begin
        tie_q <= 1'b1;
      end
      if ((state == ST_DONE) && !pivot_valid) begin
        pivot_elem_cnt <= cnt_q;
        pivot_tie      <= tie_q;
      end
      if (res_hs) begin
        pivot_elem_cnt <= '0;
        pivot_tie      <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_hpu_pivot_search_mc.sv
// Self-checking bench: two instances (TIE_LOWEST=1 and 0) share stimulus and
// are compared against a queue-based reference model of the selection rules.
module tb_hpu_pivot_search_mc;

  logic         clk = 1'b0;
  logic         rst;
  logic         pivot_start, mode, in_valid, in_last, pivot_ready;
  logic [31:0]  eps_thresh;
  logic [127:0] in_value;
  logic [7:0]   in_row_base;
  logic [3:0]   in_lane_mask;

  logic         busy_a, rdy_a, pv_a, fail_a, ovf_a;
  logic [7:0]   row_a;
  logic [31:0]  val_a;
  logic         busy_b, rdy_b, pv_b, fail_b, ovf_b;
  logic [7:0]   row_b;
  logic [31:0]  val_b;
`ifdef HPU_PIVOT_STATS_EN
  logic [8:0]   cnt_a, cnt_b;
  logic         tie_a, tie_b;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  logic [127:0] q_val[$];
  logic [3:0]   q_mask[$];
  logic [7:0]   q_base[$];

  always #5 clk = ~clk;

  hpu_pivot_search_mc #(.TIE_LOWEST(1)) u_dut_a (
    .clk(clk), .rst(rst), .pivot_start(pivot_start), .pivot_busy(busy_a),
    .mode(mode), .eps_thresh(eps_thresh), .in_valid(in_valid), .in_ready(rdy_a),
    .in_value(in_value), .in_row_base(in_row_base), .in_lane_mask(in_lane_mask),
    .in_last(in_last), .pivot_valid(pv_a), .pivot_ready(pivot_ready),
    .pivot_row(row_a), .pivot_value(val_a), .pivot_fail(fail_a), .pivot_ovf(ovf_a)
`ifdef HPU_PIVOT_STATS_EN
    , .pivot_elem_cnt(cnt_a), .pivot_tie(tie_a)
`endif
  );

  hpu_pivot_search_mc #(.TIE_LOWEST(0)) u_dut_b (
    .clk(clk), .rst(rst), .pivot_start(pivot_start), .pivot_busy(busy_b),
    .mode(mode), .eps_thresh(eps_thresh), .in_valid(in_valid), .in_ready(rdy_b),
    .in_value(in_value), .in_row_base(in_row_base), .in_lane_mask(in_lane_mask),
    .in_last(in_last), .pivot_valid(pv_b), .pivot_ready(pivot_ready),
    .pivot_row(row_b), .pivot_value(val_b), .pivot_fail(fail_b), .pivot_ovf(ovf_b)
`ifdef HPU_PIVOT_STATS_EN
    , .pivot_elem_cnt(cnt_b), .pivot_tie(tie_b)
`endif
  );

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_beats;
    q_val.delete();
    q_mask.delete();
    q_base.delete();
  endtask

  task automatic push_beat(input logic [31:0] v0, input logic [31:0] v1, input logic [31:0] v2,
                           input logic [31:0] v3, input logic [3:0] m, input logic [7:0] base);
    q_val.push_back({v3, v2, v1, v0});
    q_mask.push_back(m);
    q_base.push_back(base);
  endtask

  // Reference: walk enabled lanes in arrival order applying the selection rules.
  task automatic model(input bit m, input logic [31:0] eps, input bit tie_low,
                       output logic [7:0] erow, output logic [31:0] eval,
                       output bit efail, output bit eovf, output bit echk);
    int     n;
    bit     have, passed;
    longint babs, v, a;
    logic [31:0] raw;
    n = 0; have = 0; passed = 0; babs = 0; erow = '0; eval = '0;
    for (int b = 0; b < q_val.size(); b++) begin
      for (int i = 0; i < 4; i++) begin
        if (q_mask[b][i]) begin
          n++;
          if (n <= 256) begin
            raw = q_val[b][i*32 +: 32];
            v   = longint'($signed(raw));
            a   = (v < 0) ? -v : v;
            if (m == 1'b0) begin
              if (!have || a > babs || (!tie_low && a == babs)) begin
                have = 1; babs = a; erow = q_base[b] + 8'(i); eval = raw;
              end
            end else begin
              if (!passed && a > longint'(eps)) begin
                passed = 1; have = 1; babs = a; erow = q_base[b] + 8'(i); eval = raw;
              end else if (!have) begin
                have = 1; babs = a; erow = q_base[b] + 8'(i); eval = raw;
              end
            end
          end
        end
      end
    end
    eovf  = (n > 256);
    efail = eovf || !have || (babs <= longint'(eps));
    echk  = (m == 1'b0) || passed || !have;
  endtask

  // Start a column, stream the queued beats, and wait for the result.
  task automatic run_column(input bit m, input logic [31:0] eps, input bit bubbles,
                            output int lat, output bit tmo);
    int guard;
    tmo = 0;
    lat = 0;
    pivot_start = 1'b1; mode = m; eps_thresh = eps;
    tick();
    pivot_start = 1'b0;
    for (int b = 0; b < q_val.size(); b++) begin
      if (bubbles) begin
        in_valid = 1'b0;
        repeat ($urandom_range(0, 2)) tick();
      end
      in_value = q_val[b]; in_lane_mask = q_mask[b]; in_row_base = q_base[b];
      in_last = (b == q_val.size() - 1); in_valid = 1'b1;
      guard = 0;
      while (!rdy_a && guard < 20) begin
        tick();
        guard++;
      end
      if (!rdy_a) tmo = 1;
      tick();
    end
    in_valid = 1'b0; in_last = 1'b0;
    while (!pv_a && lat < 20) begin
      tick();
      lat++;
    end
    if (!pv_a) tmo = 1;
  endtask

  task automatic handshake;
    pivot_ready = 1'b1;
    tick();
    pivot_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; pivot_start = 0; mode = 0; eps_thresh = '0; in_valid = 0; in_last = 0;
    in_value = '0; in_row_base = '0; in_lane_mask = '0; pivot_ready = 0;
    repeat (3) tick();
    n_tests++; if ({pv_a, busy_a, rdy_a, fail_a, ovf_a} !== 5'b0) begin n_fail++; $display("FAIL reset_flags: got %b required 00000", {pv_a, busy_a, rdy_a, fail_a, ovf_a}); end
    n_tests++; if ({row_a, val_a} !== 40'h0) begin n_fail++; $display("FAIL reset_data: got row %0d value %h required 0/0", row_a, val_a); end
    n_tests++; if ({pv_b, busy_b, rdy_b, row_b, val_b} !== 43'h0) begin n_fail++; $display("FAIL reset_b: got %h required 0", {pv_b, busy_b, rdy_b, row_b, val_b}); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic;
    int lat; bit tmo;
    clear_beats();
    push_beat(32'd3, -32'sd9, 32'd5, 32'd1, 4'hF, 8'd8);
    run_column(1'b0, 32'd0, 1'b0, lat, tmo);
    n_tests++; if (tmo || lat != 2) begin n_fail++; $display("FAIL basic_latency: got %0d (timeout %0d) required 2", lat, tmo); end
    n_tests++; if (pv_b !== 1'b1) begin n_fail++; $display("FAIL basic_valid_b: got %b required 1", pv_b); end
    n_tests++; if (row_a !== 8'd9 || val_a !== -32'sd9) begin n_fail++; $display("FAIL basic_result: got row %0d value %0d required 9/-9", row_a, $signed(val_a)); end
    n_tests++; if (fail_a !== 1'b0 || ovf_a !== 1'b0) begin n_fail++; $display("FAIL basic_flags: got fail %b ovf %b required 0/0", fail_a, ovf_a); end
    n_tests++; if (busy_a !== 1'b1 || rdy_a !== 1'b0) begin n_fail++; $display("FAIL basic_busy: got busy %b in_ready %b required 1/0", busy_a, rdy_a); end
    handshake();
  endtask

  task automatic test_overflow;
    int lat; bit tmo;
    for (int pass = 0; pass < 2; pass++) begin
      clear_beats();
      for (int k = 0; k < 64; k++) begin
        push_beat(32'(4*k+1), 32'(4*k+2), 32'(4*k+3), (k == 63) ? -32'sd1000 : 32'(4*k+4), 4'hF, 8'(4*k));
      end
      if (pass == 1) push_beat(32'd5000, 32'd0, 32'd0, 32'd0, 4'b0001, 8'd0);
      run_column(1'b0, 32'd0, 1'b0, lat, tmo);
      n_tests++; if (tmo) begin n_fail++; $display("FAIL ovf_timeout: pass %0d no result", pass); end
      n_tests++; if (row_a !== 8'd255 || val_a !== -32'sd1000) begin n_fail++; $display("FAIL ovf_result: pass %0d got row %0d value %0d required 255/-1000", pass, row_a, $signed(val_a)); end
      n_tests++; if (ovf_a !== 1'(pass) || fail_a !== 1'(pass)) begin n_fail++; $display("FAIL ovf_flags: pass %0d got ovf %b fail %b required %0d/%0d", pass, ovf_a, fail_a, pass, pass); end
      handshake();
    end
  endtask

  task automatic test_tie;
    int lat; bit tmo;
    clear_beats();
    push_beat(32'd7, -32'sd7, 32'd7, 32'd0, 4'hF, 8'd20);
    run_column(1'b0, 32'd0, 1'b0, lat, tmo);
    n_tests++; if (tmo || row_a !== 8'd20 || val_a !== 32'd7) begin n_fail++; $display("FAIL tie_lowest1: got row %0d value %0d required 20/7", row_a, $signed(val_a)); end
    n_tests++; if (row_b !== 8'd22 || val_b !== 32'd7) begin n_fail++; $display("FAIL tie_lowest0: got row %0d value %0d required 22/7", row_b, $signed(val_b)); end
    handshake();
  endtask

  task automatic test_first;
    int lat; bit tmo;
    clear_beats();
    push_beat(32'd2, 32'd4, -32'sd11, 32'd50, 4'hF, 8'd40);
    push_beat(32'd99, 32'd1, 32'd2, 32'd3, 4'hF, 8'd44);
    run_column(1'b1, 32'd10, 1'b0, lat, tmo);
    n_tests++; if (tmo || row_a !== 8'd42 || val_a !== -32'sd11 || fail_a !== 1'b0) begin n_fail++; $display("FAIL first_lock: got row %0d value %0d fail %b required 42/-11/0", row_a, $signed(val_a), fail_a); end
    n_tests++; if (row_b !== 8'd42 || val_b !== -32'sd11) begin n_fail++; $display("FAIL first_lock_b: got row %0d value %0d required 42/-11", row_b, $signed(val_b)); end
    handshake();
    clear_beats();
    push_beat(32'd1, -32'sd10, 32'd10, 32'd3, 4'hF, 8'd0);
    push_beat(32'd0, 32'd5, -32'sd7, 32'd2, 4'hF, 8'd4);
    run_column(1'b1, 32'd10, 1'b0, lat, tmo);
    n_tests++; if (tmo || fail_a !== 1'b1 || fail_b !== 1'b1) begin n_fail++; $display("FAIL first_none: got fail %b/%b required 1/1", fail_a, fail_b); end
    handshake();
  endtask

  task automatic test_backpressure;
    int lat; bit tmo;
    clear_beats();
    push_beat(32'd3, -32'sd9, 32'd5, 32'd1, 4'hF, 8'd8);
    run_column(1'b0, 32'd0, 1'b0, lat, tmo);
    for (int c = 0; c < 5; c++) begin
      pivot_start = (c == 2);
      tick();
      n_tests++; if (pv_a !== 1'b1 || row_a !== 8'd9 || val_a !== -32'sd9 || rdy_a !== 1'b0) begin n_fail++; $display("FAIL hold_c%0d: got valid %b row %0d value %0d in_ready %b required 1/9/-9/0", c, pv_a, row_a, $signed(val_a), rdy_a); end
    end
    pivot_start = 1'b1;
    pivot_ready = 1'b1;
    tick();
    pivot_start = 1'b0;
    pivot_ready = 1'b0;
    n_tests++; if (pv_a !== 1'b0 || busy_a !== 1'b0) begin n_fail++; $display("FAIL hs_release: got valid %b busy %b required 0/0", pv_a, busy_a); end
    tick();
    n_tests++; if (busy_a !== 1'b0 || rdy_a !== 1'b0) begin n_fail++; $display("FAIL start_ignored: got busy %b in_ready %b required 0/0", busy_a, rdy_a); end
  endtask

  task automatic test_reset_mid;
    bit seen;
    pivot_start = 1'b1; mode = 1'b0; eps_thresh = '0;
    tick();
    pivot_start = 1'b0;
    in_value = {32'd4, 32'd3, 32'd2, 32'd1}; in_lane_mask = 4'hF; in_row_base = 8'd0;
    in_last = 1'b0; in_valid = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    #1;
    n_tests++; if ({pv_a, busy_a, rdy_a, fail_a, ovf_a, row_a, val_a} !== 45'h0) begin n_fail++; $display("FAIL reset_mid: got %h required 0", {pv_a, busy_a, rdy_a, fail_a, ovf_a, row_a, val_a}); end
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    seen = 0;
    repeat (6) begin
      tick();
      if (pv_a || pv_b || busy_a) seen = 1;
    end
    n_tests++; if (seen) begin n_fail++; $display("FAIL reset_mid_no_result: got activity 1 required 0"); end
  endtask

  task automatic test_empty_and_extremes;
    int lat; bit tmo;
    clear_beats();
    push_beat(32'd5, 32'd6, 32'd7, 32'd8, 4'b0000, 8'd77);
    run_column(1'b0, 32'd0, 1'b0, lat, tmo);
    n_tests++; if (tmo || fail_a !== 1'b1 || row_a !== 8'd0 || val_a !== 32'd0 || ovf_a !== 1'b0) begin n_fail++; $display("FAIL empty: got fail %b row %0d value %0d ovf %b required 1/0/0/0", fail_a, row_a, val_a, ovf_a); end
    handshake();
    clear_beats();
    push_beat(32'h7FFF_FFFF, 32'h8000_0000, 32'd0, 32'd0, 4'b0011, 8'd100);
    run_column(1'b0, 32'd0, 1'b0, lat, tmo);
    n_tests++; if (tmo || row_a !== 8'd101 || val_a !== 32'h8000_0000 || fail_a !== 1'b0) begin n_fail++; $display("FAIL extremes: got row %0d value %h fail %b required 101/80000000/0", row_a, val_a, fail_a); end
    handshake();
  endtask

  task automatic test_random;
    int lat; bit tmo, m, fa, fb, oa, ob, ca, cb;
    logic [31:0] eps, va, vb, lv[4];
    logic [7:0]  ra, rb;
    for (int t = 0; t < 40; t++) begin
      clear_beats();
      for (int b = 0; b < int'($urandom_range(1, 8)); b++) begin
        for (int i = 0; i < 4; i++) begin
          case ($urandom_range(0, 11))
            0:       lv[i] = 32'h8000_0000;
            1:       lv[i] = 32'h7FFF_FFFF;
            default: lv[i] = 32'(int'($urandom_range(0, 16)) - 8);
          endcase
        end
        push_beat(lv[0], lv[1], lv[2], lv[3], 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
      end
      m   = 1'($urandom_range(0, 1));
      eps = 32'($urandom_range(0, 9));
      model(m, eps, 1'b1, ra, va, fa, oa, ca);
      model(m, eps, 1'b0, rb, vb, fb, ob, cb);
      run_column(m, eps, 1'b1, lat, tmo);
      n_tests++; if (tmo || lat != 2 || pv_b !== 1'b1) begin n_fail++; $display("FAIL rnd%0d_latency: got %0d (timeout %0d, valid_b %b) required 2", t, lat, tmo, pv_b); end
      n_tests++; if (fail_a !== fa || ovf_a !== oa || fail_b !== fb || ovf_b !== ob) begin n_fail++; $display("FAIL rnd%0d_flags: got fail %b/%b ovf %b/%b required %b/%b %b/%b", t, fail_a, fail_b, ovf_a, ovf_b, fa, fb, oa, ob); end
      if (ca) begin
        n_tests++; if (row_a !== ra || val_a !== va) begin n_fail++; $display("FAIL rnd%0d_tie1: mode %0d got row %0d value %h required %0d/%h", t, m, row_a, val_a, ra, va); end
        n_tests++; if (row_b !== rb || val_b !== vb) begin n_fail++; $display("FAIL rnd%0d_tie0: mode %0d got row %0d value %h required %0d/%h", t, m, row_b, val_b, rb, vb); end
      end
      handshake();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_tie();
    test_first();
    test_backpressure();
    test_reset_mid();
    test_empty_and_extremes();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hpu_pivot_search_mc.md
Name: hpu_pivot_search_mc

Overview:
Multi-lane, parametrised pivot search unit for the HPU LU-factorisation datapath; generational successor to the single-lane hpu_top pivot search.
- Accepts LANES column candidates per beat, each tagged by row.
- Selects the pivot by one of two modes: max-|value| or first-above-threshold.
- Flags numerical failure against a programmable threshold.
- Returns the result on a valid/ready channel.

Parameters:
DATA_W, 32, signed candidate width
ROW_IDX_W, 8, logical row index width
LANES, 4, candidates per input beat (power of 2, >=1)
MAX_ELEMS, 256, max candidates per column; excess flags overflow
TIE_LOWEST, 1, 1: equal |value| keeps the earlier/lower row; 0: later row wins

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
pivot_start  in  1  start pulse; samples mode/eps_thresh
pivot_busy  out  1  high from accepted start until result handshake
mode  in  1  0 = max-abs, 1 = first |v| > eps_thresh
eps_thresh  in  DATA_W  unsigned magnitude threshold
in_valid  in  1  input beat valid
in_ready  out  1  high only in COLLECT
in_value  in  LANES*DATA_W  lane i at bits [i*DATA_W +: DATA_W], signed
in_row_base  in  ROW_IDX_W  row of lane 0; lane i row = base+i mod 2^ROW_IDX_W
in_lane_mask  in  LANES  lane enable
in_last  in  1  final beat of the column
pivot_valid  out  1  result valid
pivot_ready  in  1  result accept
pivot_row  out  ROW_IDX_W  selected row
pivot_value  out  DATA_W  selected signed value (original sign)
pivot_fail  out  1  no candidate passes threshold, or overflow
pivot_ovf  out  1  more than MAX_ELEMS enabled lanes seen

Behaviour:
Reset: all outputs 0, state IDLE, best/count registers cleared. Assertion mid-operation aborts immediately with no result emitted.

State machine: IDLE -> COLLECT -> DRAIN -> DONE -> IDLE.
- IDLE: pivot_start latches mode and eps_thresh, clears best and count, goes to COLLECT. pivot_busy=1 from the next cycle.
- COLLECT: in_ready=1. Beat accepted on in_valid&in_ready.
  - Stage 1 (pivot_lane_reduce): per-lane |v| as DATA_W-bit unsigned (|-2^(DATA_W-1)| = 2^(DATA_W-1), no saturation). Masked lanes excluded. Registered tree reduction by mode/tie rule. Within a beat, lower lane = earlier.
  - Stage 2: merge with the running best.
  - Accepting in_last -> DRAIN.
- DRAIN: one cycle, in_ready=0; stage 2 absorbs the final beat.
- DONE: pivot_valid=1, outputs stable until pivot_ready. Handshake -> IDLE; pivot_busy falls that same cycle.

Latency: in_last accepted at edge T -> pivot_valid high after edge T+2.

Mode rules:
- max-abs: strict > replaces best. Equal magnitude replaces only if TIE_LOWEST=0.
- first mode: the first candidate in arrival order with |v| > eps_thresh locks. Later beats are still consumed until in_last.

Fail: pivot_fail=1 if best |v| <= eps_thresh, no enabled lane seen, or overflow. With no enabled lane seen: pivot_row=0, pivot_value=0.

Overflow: count saturates at MAX_ELEMS+1. Lanes beyond MAX_ELEMS are ignored, and pivot_ovf=pivot_fail=1.

Ignored inputs:
- pivot_start outside IDLE.
- in_valid outside COLLECT.
- A beat with an all-zero mask and in_last=1 still terminates the column.
- Start and result handshake in the same cycle: the start is ignored (state is DONE).

Optional Feature:
HPU_PIVOT_STATS_EN
- Defined: adds outputs pivot_elem_cnt [$clog2(MAX_ELEMS+2)] (enabled lanes seen) and pivot_tie (an equal-magnitude tie occurred against the best). Both are valid with pivot_valid and reset to 0.
- Undefined: ports and counters are absent; core behaviour is identical.

Decomposition:
- hpu_pkg holds: pivot_mode_e (PIV_MAX_ABS, PIV_FIRST_NZ); pivot_state_e; pivot_cand_t struct {vld, absval, row, value} parameterised via localparams DATA_W/ROW_IDX_W.
- One sub-module, pivot_lane_reduce: abs, mask, and registered LANES-to-1 tree. The mode and tie rules live in a shared package function, used by both the tree and the stage-2 merge.

Test Plan:
1. LANES=4, one beat, values {3,-9,5,1}, base=8, mode 0, eps=0 -> row 9, value -9, fail 0, pivot_valid 2 cycles after the in_last accept.
2. 64 beats (256 elems), value=row+1, last element -1000 -> row 255, value -1000. Then one extra beat with mask 4'b0001 -> ovf=1, fail=1.
3. Tie {7,-7,7,0}: TIE_LOWEST=1 -> row base+0; TIE_LOWEST=0 -> row base+2.
4. Mode 1, eps=10, beats {2,4,-11,50},{99,...} -> row base+2, value -11. All |v|<=10 -> fail=1.
5. Hold pivot_ready=0 for 5 cycles -> pivot_valid and outputs stable, in_ready=0, start ignored. Assert rst mid-COLLECT -> all outputs 0 next cycle, no pivot_valid.
6. Mask 4'b0000 with in_last -> fail=1, row=0, value=0. Values -2^31 vs 2^31-1 -> -2^31 selected.
